// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: CPU, host and RAM signal bundle for the data memory arbiter
// Ports (all carried as interface signals):
//   cpu_*  : CPU MEM-stage load/store request, stall and read return
//   host_* : host loader/readout request, grant, burst lock and read return
//   mem_*  : single-port synchronous RAM access (rdata one cycle after a read)
// Modports: slave = arbiter side, master = requesters plus RAM side.
interface data_mem_arbiter_if #(parameter int DW = 32, parameter int AW = 32);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          host_req;
    logic          host_we;
    logic          host_lock;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  host_req, host_we, host_lock, host_addr, host_wdata,
        input  mem_rdata,
        output cpu_stall, cpu_rvalid, cpu_rdata,
        output host_gnt, host_rvalid, host_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output host_req, host_we, host_lock, host_addr, host_wdata,
        output mem_rdata,
        input  cpu_stall, cpu_rvalid, cpu_rdata,
        input  host_gnt, host_rvalid, host_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one synchronous data RAM between the CPU MEM stage and a host port
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; forces every output to 0 while asserted
//   bus   : data_mem_arbiter_if.slave carrying CPU, host and RAM signals
// Grant is combinational within the cycle: round-robin on conflict, host burst lock
// bounded by MAX_WAIT consecutive host wins while the CPU waits.
module data_mem_arbiter #(
    parameter int DW       = 32,
    parameter int AW       = 32,
    parameter int MAX_WAIT = 4
) (
    input logic                clk,
    input logic                reset,
    data_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CPU_OWN, HOST_OWN} state_t;
    localparam logic [3:0] MAXW = 4'(MAX_WAIT);
    state_t        state;
    logic          last_winner;
    logic [3:0]    wait_cnt;
    logic          rpend;
    logic          rsel;
    logic [DW-1:0] cpu_hold;
    logic [DW-1:0] host_hold;
    logic          lock_hold;
    logic          forced;
    logic          host_win;
    logic          cpu_win;
    always_comb begin
        lock_hold = state == HOST_OWN && bus.host_lock && wait_cnt < MAXW;
        forced    = wait_cnt == MAXW;
        // last_winner: 0 = CPU, 1 = HOST; on a plain conflict the other side wins
        host_win  = ~reset & bus.host_req & (~bus.cpu_req | lock_hold | (~forced & ~last_winner));
        cpu_win   = ~reset & bus.cpu_req & ~host_win;
    end
    assign bus.mem_en      = host_win | cpu_win;
    assign bus.mem_we      = host_win ? bus.host_we : cpu_win & bus.cpu_we;
    assign bus.mem_addr    = host_win ? bus.host_addr : cpu_win ? bus.cpu_addr : {AW{1'b0}};
    assign bus.mem_wdata   = host_win ? bus.host_wdata : cpu_win ? bus.cpu_wdata : {DW{1'b0}};
    assign bus.cpu_stall   = ~reset & bus.cpu_req & ~cpu_win;
    assign bus.host_gnt    = host_win;
    assign bus.cpu_rvalid  = ~reset & rpend & ~rsel;
    assign bus.host_rvalid = ~reset & rpend & rsel;
    // Non-owner data port keeps showing its last returned word
    assign bus.cpu_rdata   = reset ? {DW{1'b0}} : bus.cpu_rvalid ? bus.mem_rdata : cpu_hold;
    assign bus.host_rdata  = reset ? {DW{1'b0}} : bus.host_rvalid ? bus.mem_rdata : host_hold;
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_winner <= 1'b1;
            wait_cnt    <= 4'd0;
            rpend       <= 1'b0;
            rsel        <= 1'b0;
            cpu_hold    <= {DW{1'b0}};
            host_hold   <= {DW{1'b0}};
        end else begin
            state       <= host_win ? HOST_OWN : cpu_win ? CPU_OWN : IDLE;
            if (bus.mem_en)
                last_winner <= host_win;
            wait_cnt    <= (host_win & bus.cpu_req) ? (forced ? wait_cnt : wait_cnt + 4'd1) : 4'd0;
            rpend       <= bus.mem_en & ~bus.mem_we;
            rsel        <= host_win;
            cpu_hold    <= bus.cpu_rdata;
            host_hold   <= bus.host_rdata;
        end
    end
endmodule
